// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the 16-bit CPU front end.
//   - fetch FSM state encoding
//   - reset PC and NOP word defaults
//   - instruction field positions used by fetch, decode and ALU control
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

  // Instruction field positions.
  localparam int OP_MAJOR_HI = 15;
  localparam int OP_MAJOR_LO = 12;
  localparam int OP_COND_HI  = 11;
  localparam int OP_COND_LO  = 8;
  localparam int OP_EXT_HI   = 7;
  localparam int OP_EXT_LO   = 4;

  function automatic logic [3:0] op_major(input logic [15:0] instr);
    return instr[OP_MAJOR_HI:OP_MAJOR_LO];
  endfunction

  function automatic logic [3:0] op_cond(input logic [15:0] instr);
    return instr[OP_COND_HI:OP_COND_LO];
  endfunction

  function automatic logic [3:0] op_ext(input logic [15:0] instr);
    return instr[OP_EXT_HI:OP_EXT_LO];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: 16-bit program counter.
//   clk, rst_n : clock, asynchronous active-low reset (loads RESET_PC)
//   load       : take target (has priority over inc)
//   inc        : advance by one word, wrapping FFFF -> 0000
//   target     : redirect value, used unmodified
//   pc         : current program counter
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        inc,
  input  logic [15:0] target,
  output logic [15:0] pc
);

  logic [15:0] pc_r;

  // PC register: redirect wins over sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= target;
    end else if (inc) begin
      pc_r <= pc_r + 16'd1;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch stage.
//   clk, rst_n       : clock, asynchronous active-low reset
//   mem_req/addr     : read request to instruction memory, addr = pc_out
//   mem_ack/rdata    : memory response
//   stall            : hold off new fetches (only sampled in IDLE/HOLD)
//   instr_out        : held instruction (NOP_WORD when not valid)
//   pc_out           : PC of the held instruction
//   instr_valid      : instr_out holds a real fetched word
//   exec_done        : downstream finished the held instruction
//   branch_taken/target : redirect qualifier and destination
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        stall,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [15:0] branch_target
);

  fetch_state_e state_r;
  fetch_state_e state_s;
  logic         pc_inc_s;
  logic         pc_load_s;
  logic         ir_load_s;
  logic         ir_clear_s;
  logic [15:0]  pc_s;
  logic [15:0]  instr_r;
  logic         valid_r;
  logic         mem_req_r;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pc_load_s),
    .inc    (pc_inc_s),
    .target (branch_target),
    .pc     (pc_s)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_s    = state_r;
    pc_inc_s   = 1'b0;
    pc_load_s  = 1'b0;
    ir_load_s  = 1'b0;
    ir_clear_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!stall) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        // stall is deliberately not looked at: an issued request completes.
        if (mem_ack) begin
          ir_load_s = 1'b1;
          state_s   = HOLD;
        end else begin
          state_s = FETCH;
        end
      end
      HOLD: begin
        if (exec_done) begin
          ir_clear_s = 1'b1;
          if (branch_taken) begin
            pc_load_s = 1'b1;
          end else begin
            pc_inc_s = 1'b1;
          end
          if (stall) begin
            state_s = IDLE;
          end else begin
            state_s = FETCH;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, instruction register and registered request.
  // mem_req is registered from the next state so it is high exactly
  // while the FSM sits in FETCH, and drops with reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      instr_r   <= NOP_WORD;
      valid_r   <= 1'b0;
      mem_req_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      mem_req_r <= (state_s == FETCH);
      if (ir_load_s) begin
        instr_r <= mem_rdata;
        valid_r <= 1'b1;
      end else if (ir_clear_s) begin
        instr_r <= NOP_WORD;
        valid_r <= 1'b0;
      end else begin
        instr_r <= instr_r;
        valid_r <= valid_r;
      end
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = pc_s;
  assign pc_out      = pc_s;
  assign instr_out   = instr_r;
  assign instr_valid = valid_r;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Multi-cycle instruction fetch stage for the 16-bit CPU. Sits directly upstream of the ALU control stage.
- Owns the program counter and instruction register. Reads instruction words from memory over a req/ack handshake.
- Presents the held instruction plus the current PC to the decode/ALU-control path, and advances or redirects the PC when execute signals completion.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (word address).
- NOP_WORD, 16'h0000, value driven on instr_out while no valid instruction is held.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  16  word address of the requested read; equals pc_out.
- mem_ack  in  1  memory has driven mem_rdata this cycle.
- mem_rdata  in  16  instruction word returned by memory.
- stall  in  1  hold off new fetches (hazard or halt).
- instr_out  out  16  held instruction word, feeds ALU control and decoder.
- pc_out  out  16  PC of the held instruction, feeds the r1/PC mux.
- instr_valid  out  1  instr_out is a real fetched instruction.
- exec_done  in  1  downstream has finished the held instruction.
- branch_taken  in  1  qualifies exec_done: redirect the PC.
- branch_target  in  16  new PC when branch_taken (ALU PC+disp or jump register).

Behaviour:
- Reset is asynchronous and active-low; there is one clock.
- While rst_n=0, outputs are forced immediately: pc_out=RESET_PC, instr_out=NOP_WORD, instr_valid=0, mem_req=0, FSM=IDLE.
- FSM states: IDLE, FETCH, HOLD.
- IDLE:
  - mem_req=0.
  - If stall=0, go to FETCH next cycle.
  - If stall=1, remain in IDLE.
- FETCH:
  - mem_req=1 and mem_addr=pc_out, held stable until ack.
  - On mem_ack=1: instr_out<=mem_rdata, instr_valid<=1, go to HOLD.
  - mem_req deasserts the cycle after ack.
  - stall is ignored once FETCH has been entered; an issued request always completes.
- HOLD:
  - instr_out, pc_out and instr_valid are stable; mem_req=0.
  - On exec_done=1 with branch_taken=1: pc<=branch_target.
  - On exec_done=1 with branch_taken=0: pc<=pc+1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  - In both exec_done cases: instr_valid<=0, instr_out<=NOP_WORD, then go to IDLE if stall=1, else FETCH.
- Latency:
  - Minimum 1 cycle from FETCH entry to HOLD with zero-wait memory (ack in the first FETCH cycle).
  - Total per instruction is 2 cycles plus execute time.
- mem_ack outside FETCH is ignored; no state change.
- exec_done outside HOLD is ignored.
- branch_taken without exec_done has no effect.
- exec_done and stall together in HOLD: the PC update still happens, then the FSM goes to IDLE.
- branch_target is used unmodified; no alignment or masking.
- Reset asserted mid-FETCH: mem_req drops asynchronously and the outstanding ack is discarded; no handshake completion is promised.
- No internal timeout: FETCH waits indefinitely for mem_ack.

Decomposition:
- Shared cpu_pkg holds:
  - FSM state encoding (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2).
  - RESET_PC default.
  - NOP_WORD constant.
  - Opcode field positions ([15:12] major, [7:4] ext, [11:8] cond), reused by ALU control and decode.
- One natural sub-module: pc_reg. It holds the 16-bit register with load, increment and branch-select, plus async active-low reset to RESET_PC.
- The FSM and instruction register stay in fetch_unit.

Test Plan:
- Reset release, stall=0, memory acks in the first cycle with 16'h5A21 → mem_req=1 with mem_addr=0000 on the first active cycle; next cycle instr_out=5A21, instr_valid=1, pc_out=0000.
- In HOLD, exec_done=1, branch_taken=0 → instr_valid=0 next cycle, new fetch at mem_addr=0001.
- In HOLD with pc=0010, exec_done=1, branch_taken=1, branch_target=0040 → next mem_addr=0040; pc_out=0040 once the new instruction is held.
- pc=FFFF, sequential completion → next fetch at mem_addr=0000.
- mem_ack delayed 3 cycles → mem_req and mem_addr=pc stay stable for all 4 cycles; a spurious mem_ack during HOLD leaves instr_out unchanged.
- stall=1 at exec_done → FSM goes to IDLE with mem_req=0; releasing stall starts a fetch next cycle. rst_n pulsed low mid-FETCH → mem_req=0 and pc_out=RESET_PC immediately, without waiting for a clock edge.
